// File: rtl/custom_op_sequencer.sv
// custom_op_sequencer
//   Multi-cycle sequencer for C-type custom instructions (FFT, ENCRYPT,
//   DECRYPT). On issue it stalls the core and streams len words from data
//   memory into the custom accelerator, one read at a time. It then drains
//   exactly len results from the accelerator back to memory and releases
//   the stall. While busy it owns the data-memory port.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   issue_valid_i/issue_ready_o  instruction handshake with decode
//   custom_instr_i               one-hot op: 001 FFT, 010 ENCRYPT, 100 DECRYPT
//   src_addr_i, dst_addr_i       first source / destination word address
//   len_i, key_i                 word count, cipher key (unused for FFT)
//   stall_o                      freeze fetch/decode
//   mem_*                        single-outstanding request memory port
//   acc_start_o                  one-cycle start pulse to the accelerator
//   acc_op_o, acc_key_o          latched op/key, held while busy
//   acc_in_*                     valid/ready word stream into the accelerator
//   acc_out_*                    valid/ready result stream from the accelerator
//   done_o, err_o                one-cycle completion / rejection pulses
module custom_op_sequencer #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 19,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [2:0]        custom_instr_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] key_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              acc_start_o,
  output logic [2:0]        acc_op_o,
  output logic [DATA_W-1:0] acc_key_o,
  output logic              acc_in_valid_o,
  output logic [DATA_W-1:0] acc_in_data_o,
  input  logic              acc_in_ready_i,
  input  logic              acc_out_valid_i,
  input  logic [DATA_W-1:0] acc_out_data_i,
  output logic              acc_out_ready_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_PUSH,
    S_WR_WAIT,
    S_WR_REQ,
    S_FIN
  } state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] key_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rd_cnt;
  logic [LEN_W-1:0]  wr_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic              start_q;

  logic              op_legal;
  logic [LEN_W-1:0]  rd_cnt_nx;
  logic [LEN_W-1:0]  wr_cnt_nx;

  always_comb begin
    op_legal = 1'b0;
    case (custom_instr_i)
      3'b001, 3'b010, 3'b100: op_legal = 1'b1;
      default:                op_legal = 1'b0;
    endcase
  end

  assign rd_cnt_nx = rd_cnt + LEN_W'(1);
  assign wr_cnt_nx = wr_cnt + LEN_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      op_q    <= '0;
      key_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue_valid_i) begin
            op_q   <= custom_instr_i;
            key_q  <= key_i;
            src_q  <= src_addr_i;
            dst_q  <= dst_addr_i;
            len_q  <= len_i;
            rd_cnt <= '0;
            wr_cnt <= '0;
            // Rejected ops skip the transfer entirely and report from FIN.
            if (!op_legal || len_i == '0) begin
              err_q <= 1'b1;
              state <= S_FIN;
            end else begin
              err_q   <= 1'b0;
              start_q <= 1'b1;
              state   <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: begin
          if (mem_gnt_i) state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (mem_rvalid_i) begin
            rdata_q <= mem_rdata_i;
            state   <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (acc_in_ready_i) begin
            rd_cnt <= rd_cnt_nx;
            state  <= (rd_cnt_nx == len_q) ? S_WR_WAIT : S_RD_REQ;
          end
        end
        S_WR_WAIT: begin
          if (acc_out_valid_i) begin
            wdata_q <= acc_out_data_i;
            state   <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (mem_gnt_i) begin
            wr_cnt <= wr_cnt_nx;
            state  <= (wr_cnt_nx == len_q) ? S_FIN : S_WR_WAIT;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // All state-dependent outputs decode only the registered state and
  // latched data; stall_o alone looks at issue_valid_i so the issuing
  // instruction is frozen in its accept cycle.
  always_comb begin
    issue_ready_o   = (state == S_IDLE);
    stall_o         = (state == S_IDLE && issue_valid_i) ||
                      (state != S_IDLE && state != S_FIN);
    mem_req_o       = (state == S_RD_REQ) || (state == S_WR_REQ);
    mem_wr_o        = (state == S_WR_REQ);
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    if (state == S_RD_REQ) mem_addr_o = src_q + ADDR_W'(rd_cnt);
    if (state == S_WR_REQ) begin
      mem_addr_o  = dst_q + ADDR_W'(wr_cnt);
      mem_wdata_o = wdata_q;
    end
    acc_start_o     = start_q;
    acc_op_o        = (state != S_IDLE && !err_q) ? op_q  : '0;
    acc_key_o       = (state != S_IDLE && !err_q) ? key_q : '0;
    acc_in_valid_o  = (state == S_PUSH);
    acc_in_data_o   = (state == S_PUSH) ? rdata_q : '0;
    acc_out_ready_o = (state == S_WR_WAIT);
    done_o          = (state == S_FIN) && !err_q;
    err_o           = (state == S_FIN) && err_q;
  end

endmodule
